drum_dot_ctrl: RTL and testbench
================================

DRUM_DOT_CTRL -- requirements
Module: drum_dot_ctrl

Interface
REQ-001 The block SHALL have the parameter MAX_LEN_W, default 8, meaning the width of the group-count input.
REQ-002 The block SHALL have the parameter ACC_W, default 43, meaning the accumulator width (35 + MAX_LEN_W).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 In_Start  in  1  start request, sampled only in IDLE.
REQ-006 In_Len  in  MAX_LEN_W  number of 8-lane groups in the dot product, sampled with In_Start.
REQ-007 In_Valid  in  1  operand group valid.
REQ-008 Out_Ready  out  1  controller accepts an operand group.
REQ-009 In_IFM_1..In_IFM_8  in  16 each  unsigned IFM operands of the current group.
REQ-010 In_Weight_1..In_Weight_8  in  16 each  unsigned weight operands of the current group.
REQ-011 Out_Busy  out  1  high in any state other than IDLE.
REQ-012 Out_Valid  out  1  Out_Result is valid.
REQ-013 In_Ready  in  1  result consumer ready.
REQ-014 Out_Result  out  ACC_W  accumulated approximate dot product.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN, DRAIN and DONE.
REQ-016 Transitions:
- IDLE->RUN on In_Start with In_Len!=0.
- IDLE->DONE on In_Start with In_Len==0.
- RUN->DRAIN on acceptance of the last group.
- DRAIN->DONE unconditionally.
- DONE->IDLE when In_Ready is high.
REQ-017 Out_Ready SHALL equal (state==RUN); a group is accepted when In_Valid and Out_Ready are both high.
REQ-018 Each accepted group SHALL be captured into operand registers driving the DRUM unit; the next cycle the 35-bit DRUM output SHALL be zero-extended and added into the accumulator.
REQ-019 The accumulator SHALL clear to 0 on the IDLE->RUN and IDLE->DONE transitions.
REQ-020 A group counter SHALL increment on each acceptance; the last group is the one where counter==In_Len-1 (In_Len latched at start).
REQ-021 Out_Valid SHALL be high exactly in DONE; Out_Result SHALL hold the accumulator and stay stable until In_Ready is sampled high.
REQ-022 Latency from acceptance of the last group to Out_Valid SHALL be 2 cycles; for In_Len==0 it SHALL be 1 cycle after In_Start, with Out_Result 0.
REQ-023 In_Start outside IDLE SHALL be ignored, with no effect on the counter, the accumulator or the latched length.
REQ-024 Gaps in In_Valid during RUN SHALL stall the counter and accumulation without loss.
REQ-025 For In_Len=2^MAX_LEN_W-1 the accumulator SHALL not overflow, since ACC_W is sized for it.
REQ-026 If In_Ready is high on entry to DONE, the result SHALL be presented for that one cycle and the FSM SHALL return to IDLE on the next edge.

Reset
REQ-027 On rst:
- State SHALL be IDLE asynchronously.
- Out_Ready, Out_Valid and Out_Busy SHALL be 0.
- Out_Result, the accumulator, the counter, the latched length and the operand registers SHALL be 0.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL abort the operation, and the pending result SHALL be discarded.

Structure
REQ-029 A shared package drum_pkg SHALL hold:
- the constants DATA_W=16, LANES=8, DRUM_OUT_W=35 and the default ACC_W;
- the state enum type.
REQ-030 The combinational 8-lane DRUM dot-product unit SHALL be the single sub-module, instantiated as DRUM_example.

Verification
REQ-031 rst, then In_Start with In_Len=4 and four back-to-back groups with all IFM=3 and all Weight=2 -> Out_Valid 2 cycles after the 4th acceptance, with Out_Result=192.
REQ-032 In_Start with In_Len=0 -> Out_Valid the next cycle with Out_Result=0; Out_Ready never asserts.
REQ-033 In_Len=3 with In_Valid toggled 1,0,0,1,0,1 and group values IFM=1/Weight=1 -> Out_Result=24, with exactly 3 acceptances counted.
REQ-034 Result held in DONE with In_Ready=0 for 5 cycles -> Out_Result stable and Out_Valid high; In_Ready=1 -> IDLE the next cycle; an In_Start pulse during DONE is ignored.
REQ-035 rst asserted after 2 of 4 groups -> all outputs 0 immediately; a new run with In_Len=1 and IFM=5/Weight=4 -> Out_Result=160.
REQ-036 In_Len=255 with all IFM=Weight=63 (exact DRUM range) -> Out_Result=255*8*3969=8096760, with no overflow.

Source files
------------

// File: rtl/drum_dot_ctrl_pkg.sv
// Shared constants and FSM state type for the DRUM dot-product controller.
// DRUM keeps DRUM_K significant bits per operand; smaller values are exact.
package drum_pkg;

    localparam int DATA_W     = 16;
    localparam int LANES      = 8;
    localparam int DRUM_OUT_W = 35;
    localparam int DEF_ACC_W  = 43;
    localparam int DRUM_K     = 6;
    localparam int PROD_W     = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/drum_dot_ctrl_if.sv
// Operand/result handshake bundle between the requester and the controller.
// master drives operands and consumes results; slave is the controller.
interface drum_dot_ctrl_if #(
    parameter int MAX_LEN_W = 8,
    parameter int ACC_W     = 43
) ();

    logic                        In_Start;
    logic [MAX_LEN_W-1:0]        In_Len;
    logic                        In_Valid;
    logic                        Out_Ready;
    logic [drum_pkg::DATA_W-1:0] In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4;
    logic [drum_pkg::DATA_W-1:0] In_IFM_5, In_IFM_6, In_IFM_7, In_IFM_8;
    logic [drum_pkg::DATA_W-1:0] In_Weight_1, In_Weight_2;
    logic [drum_pkg::DATA_W-1:0] In_Weight_3, In_Weight_4;
    logic [drum_pkg::DATA_W-1:0] In_Weight_5, In_Weight_6;
    logic [drum_pkg::DATA_W-1:0] In_Weight_7, In_Weight_8;
    logic                        Out_Busy;
    logic                        Out_Valid;
    logic                        In_Ready;
    logic [ACC_W-1:0]            Out_Result;

    modport master (
        output In_Start, In_Len, In_Valid, In_Ready,
        output In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4,
        output In_IFM_5, In_IFM_6, In_IFM_7, In_IFM_8,
        output In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
        output In_Weight_5, In_Weight_6, In_Weight_7, In_Weight_8,
        input  Out_Ready, Out_Busy, Out_Valid, Out_Result
    );

    modport slave (
        input  In_Start, In_Len, In_Valid, In_Ready,
        input  In_IFM_1, In_IFM_2, In_IFM_3, In_IFM_4,
        input  In_IFM_5, In_IFM_6, In_IFM_7, In_IFM_8,
        input  In_Weight_1, In_Weight_2, In_Weight_3, In_Weight_4,
        input  In_Weight_5, In_Weight_6, In_Weight_7, In_Weight_8,
        output Out_Ready, Out_Busy, Out_Valid, Out_Result
    );

endinterface

// File: rtl/drum_dot_ctrl_drum.sv
// Combinational 8-lane DRUM approximate dot product.
// Each operand keeps DRUM_K bits from its leading one, LSB forced to 1.
module drum_dot_ctrl_drum
    import drum_pkg::*;
(
    input  logic [LANES-1:0][DATA_W-1:0] i_ifm,
    input  logic [LANES-1:0][DATA_W-1:0] i_wgt,
    output logic [DRUM_OUT_W-1:0]        o_dot
);

    function automatic logic [4:0] f_shift(input logic [DATA_W-1:0] a);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < DATA_W; i++)
            if (a[i]) p = 5'(i);
        return (p < 5'(DRUM_K)) ? 5'd0 : p - 5'(DRUM_K - 1);
    endfunction

    function automatic logic [DRUM_K-1:0] f_mant(
        input logic [DATA_W-1:0] a,
        input logic [4:0]        sh
    );
        logic [DATA_W-1:0] t;
        t = a >> sh;
        if (sh == 5'd0)
            return t[DRUM_K-1:0];
        return t[DRUM_K-1:0] | DRUM_K'(1);
    endfunction

    function automatic logic [PROD_W-1:0] f_prod(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [4:0]        sa, sb;
        logic [PROD_W-1:0] ma, mb;
        sa = f_shift(a);
        sb = f_shift(b);
        ma = PROD_W'(f_mant(a, sa));
        mb = PROD_W'(f_mant(b, sb));
        return (ma * mb) << (sa + sb);
    endfunction

    // Sum of the eight approximate lane products
    always_comb begin
        o_dot = '0;
        for (int l = 0; l < LANES; l++)
            o_dot = o_dot + DRUM_OUT_W'(f_prod(i_ifm[l], i_wgt[l]));
    end

endmodule

// File: rtl/drum_dot_ctrl.sv
// Sequences operand groups through the DRUM unit and accumulates the result.
// Operands are registered; their DRUM sum is accumulated one cycle later.
module drum_dot_ctrl
    import drum_pkg::*;
#(
    parameter int MAX_LEN_W = 8,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic           clk,
    input  logic           rst,
    drum_dot_ctrl_if.slave bus
);

    state_t                        r_state;
    logic [MAX_LEN_W-1:0]          r_len;
    logic [MAX_LEN_W-1:0]          r_cnt;
    logic [ACC_W-1:0]              r_acc;
    logic                          r_op_vld;
    logic                          r_ready;
    logic                          r_busy;
    logic                          r_valid;
    logic [LANES-1:0][DATA_W-1:0]  r_ifm;
    logic [LANES-1:0][DATA_W-1:0]  r_wgt;
    logic [LANES-1:0][DATA_W-1:0]  w_ifm;
    logic [LANES-1:0][DATA_W-1:0]  w_wgt;
    logic [DRUM_OUT_W-1:0]         w_dot;
    logic                          w_last;

    assign w_ifm = {bus.In_IFM_8, bus.In_IFM_7, bus.In_IFM_6,
                    bus.In_IFM_5, bus.In_IFM_4, bus.In_IFM_3,
                    bus.In_IFM_2, bus.In_IFM_1};
    assign w_wgt = {bus.In_Weight_8, bus.In_Weight_7,
                    bus.In_Weight_6, bus.In_Weight_5,
                    bus.In_Weight_4, bus.In_Weight_3,
                    bus.In_Weight_2, bus.In_Weight_1};

    assign w_last = (r_cnt == r_len - MAX_LEN_W'(1));

    drum_dot_ctrl_drum DRUM_example (
        .i_ifm (r_ifm),
        .i_wgt (r_wgt),
        .o_dot (w_dot)
    );

    assign bus.Out_Ready  = r_ready;
    assign bus.Out_Busy   = r_busy;
    assign bus.Out_Valid  = r_valid;
    assign bus.Out_Result = r_acc;

    // Controller FSM with registered handshake outputs and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_op_vld <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_ifm    <= '0;
            r_wgt    <= '0;
        end else begin
            r_op_vld <= 1'b0;
            if (r_op_vld)
                r_acc <= r_acc + ACC_W'(w_dot);
            unique case (r_state)
                IDLE: begin
                    if (bus.In_Start) begin
                        r_len  <= bus.In_Len;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (bus.In_Len != '0) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.In_Valid) begin
                        r_ifm    <= w_ifm;
                        r_wgt    <= w_wgt;
                        r_op_vld <= 1'b1;
                        r_cnt    <= r_cnt + MAX_LEN_W'(1);
                        if (w_last) begin
                            r_state <= DRAIN;
                            r_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    r_state <= DONE;
                    r_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.In_Ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_dot_ctrl.sv
// Scoreboard bench for drum_dot_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares when Out_Valid rises.
module tb_drum_dot_ctrl;
    import drum_pkg::*;

    localparam int LW = 8;
    localparam int AW = 43;

    typedef struct {
        logic [AW-1:0] res;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   last_evt = 0;
    int   n_acc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    drum_dot_ctrl_if #(.MAX_LEN_W(LW), .ACC_W(AW)) bus ();

    drum_dot_ctrl #(.MAX_LEN_W(LW), .ACC_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: track start/acceptance cycles, compare each new result
    initial begin : mon
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (bus.In_Start && !bus.Out_Busy) last_evt = cyc;
                if (bus.In_Valid && bus.Out_Ready) begin
                    last_evt = cyc;
                    n_acc++;
                end
                if (bus.Out_Valid && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_valid", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("result", 64'(bus.Out_Result), 64'(e.res));
                        check("latency", 64'(cyc - last_evt), 64'(e.lat));
                    end
                end
                prev_v = bus.Out_Valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [127:0] a, input logic [127:0] b);
        bus.In_IFM_1 = a[15:0];     bus.In_Weight_1 = b[15:0];
        bus.In_IFM_2 = a[31:16];    bus.In_Weight_2 = b[31:16];
        bus.In_IFM_3 = a[47:32];    bus.In_Weight_3 = b[47:32];
        bus.In_IFM_4 = a[63:48];    bus.In_Weight_4 = b[63:48];
        bus.In_IFM_5 = a[79:64];    bus.In_Weight_5 = b[79:64];
        bus.In_IFM_6 = a[95:80];    bus.In_Weight_6 = b[95:80];
        bus.In_IFM_7 = a[111:96];   bus.In_Weight_7 = b[111:96];
        bus.In_IFM_8 = a[127:112];  bus.In_Weight_8 = b[127:112];
    endtask

    task automatic start(input int len);
        bus.In_Len   = LW'(len);
        bus.In_Start = 1'b1;
        tick();
        bus.In_Start = 1'b0;
    endtask

    task automatic send(input logic [127:0] a, input logic [127:0] b);
        int k;
        set_ops(a, b);
        bus.In_Valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.Out_Ready) break;
        end
        if (k == 50) check("ready_timeout", 64'd0, 64'd1);
        tick();
        bus.In_Valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.Out_Valid) break;
        end
        if (k == 50) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.Out_Busy) break;
        end
        if (k == 50) check("idle_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic push(input logic [AW-1:0] r, input int lat);
        exp_t e;
        e.res = r;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    initial begin
        logic [5:0] pat;
        bus.In_Start = 1'b0;
        bus.In_Len   = '0;
        bus.In_Valid = 1'b0;
        bus.In_Ready = 1'b1;
        set_ops('0, '0);
        repeat (3) tick();
        check("rst_ready",  64'(bus.Out_Ready),  64'd0);
        check("rst_valid",  64'(bus.Out_Valid),  64'd0);
        check("rst_busy",   64'(bus.Out_Busy),   64'd0);
        check("rst_result", 64'(bus.Out_Result), 64'd0);
        rst = 1'b0;
        tick();

        // four back-to-back groups 3*2 per lane
        push(43'd192, 2);
        start(4);
        repeat (4) send({8{16'd3}}, {8{16'd2}});
        wait_idle();

        // zero-length request
        push(43'd0, 1);
        start(0);
        check("len0_ready", 64'(bus.Out_Ready), 64'd0);
        wait_idle();

        // In_Valid gaps 1,0,0,1,0,1
        push(43'd24, 2);
        n_acc = 0;
        start(3);
        set_ops({8{16'd1}}, {8{16'd1}});
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            bus.In_Valid = pat[i];
            tick();
        end
        bus.In_Valid = 1'b0;
        wait_idle();
        check("acc_count", 64'(n_acc), 64'd3);

        // hold in DONE with In_Ready low; stray start ignored
        bus.In_Ready = 1'b0;
        push(43'd96, 2);
        start(2);
        repeat (2) send({8{16'd2}}, {8{16'd3}});
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid",  64'(bus.Out_Valid),  64'd1);
            check("hold_result", 64'(bus.Out_Result), 64'd96);
            bus.In_Start = (i == 2);
            bus.In_Len   = 8'd1;
            @(negedge clk);
        end
        bus.In_Start = 1'b0;
        bus.In_Ready = 1'b1;
        @(negedge clk);
        check("release_busy",  64'(bus.Out_Busy),  64'd0);
        check("release_valid", 64'(bus.Out_Valid), 64'd0);
        tick();
        tick();
        check("stray_start", 64'(bus.Out_Busy), 64'd0);

        // abort mid-run, then a fresh single-group run
        start(4);
        repeat (2) send({8{16'd9}}, {8{16'd9}});
        rst = 1'b1;
        #1;
        check("abort_ready",  64'(bus.Out_Ready),  64'd0);
        check("abort_valid",  64'(bus.Out_Valid),  64'd0);
        check("abort_busy",   64'(bus.Out_Busy),   64'd0);
        check("abort_result", 64'(bus.Out_Result), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        push(43'd160, 2);
        start(1);
        send({8{16'd5}}, {8{16'd4}});
        wait_idle();

        // full-length run at the exact DRUM range limit
        push(43'd8096760, 2);
        start(255);
        repeat (255) send({8{16'd63}}, {8{16'd63}});
        wait_idle();

        // distinct lanes: sum of i*(9-i) for i=1..8
        push(43'd120, 2);
        start(1);
        send({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
             {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8});
        wait_idle();

        // truncated operands: 1000 -> 63<<4, product 3969<<8 per lane
        push(43'd8128512, 2);
        start(1);
        send({8{16'd1000}}, {8{16'd1000}});
        wait_idle();

        repeat (3) tick();
        check("queue_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
